pc_sequencer: RTL and testbench

//  Program-counter sequencer directly downstream of the jump-condition stage.

---
 rtl/pc_sequencer.sv | 77 +++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps/jumps the fetch PC, flags one flush cycle per taken jump, halts terminally.
// Define JMP_REL_EN to treat jmp_target as a two's-complement offset from pc instead of an absolute address.
module pc_sequencer #(
   parameter int unsigned             ADDR_W     = 8,
   parameter logic [ADDR_W-1:0]       RESET_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_target,
   input  logic              stall,
   input  logic              halt_req,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_valid,
   output logic              flush,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_RUN,
      S_FLUSH,
      S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] jmp_pc;

`ifdef JMP_REL_EN
   assign jmp_pc = pc_q + jmp_target;
`else
   assign jmp_pc = jmp_target;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         S_RUN: begin
            // halt outranks jump, and a jump is taken even while stalled
            if (halt_req) begin
               state_d = S_HALT;
            end else if (jmp_en) begin
               pc_d    = jmp_pc;
               state_d = S_FLUSH;
            end else if (!stall) begin
               pc_d    = pc_q + ADDR_W'(1);
            end
         end
         S_FLUSH: begin
            state_d = halt_req ? S_HALT : S_RUN;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= RESET_ADDR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign pc          = pc_q;
   assign flush       = (state_q == S_FLUSH);
   assign halted      = (state_q == S_HALT);
   assign fetch_valid = (state_q == S_RUN) & ~stall & ~rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes reference-model expectations, monitor pops and compares.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       jmp_en = 1'b0;
   logic [7:0] jmp_target = '0;
   logic       stall = 1'b0;
   logic       halt_req = 1'b0;
   logic [7:0] pc;
   logic       fetch_valid;
   logic       flush;
   logic       halted;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut (
      .clk(clk),
      .rst(rst),
      .jmp_en(jmp_en),
      .jmp_target(jmp_target),
      .stall(stall),
      .halt_req(halt_req),
      .pc(pc),
      .fetch_valid(fetch_valid),
      .flush(flush),
      .halted(halted)
   );

   typedef struct {
      logic [7:0] pc;
      bit         fv;
      bit         fl;
      bit         hl;
   } exp_t;

   exp_t  exp_q[$];
   int    errors = 0;
   int    checks = 0;

   // reference model: mode is "RUN", "FLUSH" or "HALT"
   int    m_pc = 0;
   string m_mode = "RUN";

   task automatic step(input bit r, input bit j, input logic [7:0] t, input bit s, input bit h);
      exp_t e;
      @(negedge clk);
      rst = r; jmp_en = j; jmp_target = t; stall = s; halt_req = h;
      if (r) begin
         m_pc = 0;
         m_mode = "RUN";
      end else if (m_mode == "FLUSH") begin
         m_mode = h ? "HALT" : "RUN";
      end else if (m_mode == "RUN") begin
         if (h) m_mode = "HALT";
         else if (j) begin
`ifdef JMP_REL_EN
            m_pc = (m_pc + int'(t)) % 256;
`else
            m_pc = int'(t);
`endif
            m_mode = "FLUSH";
         end else if (!s) m_pc = (m_pc + 1) % 256;
      end
      e.pc = m_pc[7:0];
      e.fv = (m_mode == "RUN") && !s && !r;
      e.fl = (m_mode == "FLUSH");
      e.hl = (m_mode == "HALT");
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks += 4;
         if (pc !== e.pc) begin
            errors++;
            $display("FAIL pc: got %02h expected %02h at %0t", pc, e.pc, $time);
         end
         if (fetch_valid !== e.fv) begin
            errors++;
            $display("FAIL fetch_valid: got %b expected %b at %0t", fetch_valid, e.fv, $time);
         end
         if (flush !== e.fl) begin
            errors++;
            $display("FAIL flush: got %b expected %b at %0t", flush, e.fl, $time);
         end
         if (halted !== e.hl) begin
            errors++;
            $display("FAIL halted: got %b expected %b at %0t", halted, e.hl, $time);
         end
      end
   end

   initial begin
      int guard;
      // reset then free run
      step(1, 0, 8'h00, 0, 0);
      step(1, 0, 8'h00, 0, 0);
      idle(5);
      // stall three cycles, then jump while stalled
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
      step(0, 1, 8'h80, 1, 0);
      idle(3);
      // run to 0x10 and jump to 0x40
      step(1, 0, 8'h00, 0, 0);
      guard = 0;
      while (m_pc != 8'h10 && guard < 300) begin idle(1); guard++; end
      step(0, 1, 8'h40, 0, 0);
      idle(3);
      // jump with offset 0xF0 from 0x10 and then 0x05 (absolute: lands on those addresses)
      guard = 0;
      while (m_pc != 8'h10 && guard < 300) begin idle(1); guard++; end
      step(0, 1, 8'hF0, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      step(0, 1, 8'h05, 0, 0);
      idle(2);
      // wrap through 0xFF
      guard = 0;
      while (m_pc != 8'hFF && guard < 300) begin idle(1); guard++; end
      idle(2);
      // halt outranks a simultaneous jump
      guard = 0;
      while (m_pc != 8'h22 && guard < 300) begin idle(1); guard++; end
      step(0, 1, 8'h99, 0, 1);
      for (int i = 0; i < 6; i++)
         step(0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      step(1, 0, 8'h00, 0, 0);
      idle(2);
      // reset during the flush cycle
      step(0, 1, 8'h40, 0, 0);
      step(1, 1, 8'h60, 0, 1);
      idle(2);
      // halt requested during flush
      step(0, 1, 8'h30, 0, 0);
      step(0, 0, 8'h00, 0, 1);
      idle(2);
      step(1, 0, 8'h00, 0, 0);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0), 8'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
      @(negedge clk);
      rst = 1'b0; jmp_en = 1'b0; stall = 1'b0; halt_req = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
